// File: rtl/uart_tx_rx.sv
// -----------------------------------------------------------------------------
// uart_tx_rx
// Full-duplex 8N1 UART: one start bit, eight data bits LSB first, one stop bit,
// no parity, fixed bit period of clks_per_bit system clocks. The transmitter
// and receiver are independent and may run at the same time.
//
// Parameters
//   clks_per_bit   system clocks per UART bit (clk_freq / baud), >= 4
//
// Ports
//   clk            in   1  system clock, rising edge
//   rst_n          in   1  asynchronous active-low reset
//   i_data_avail   in   1  TX request level, only looked at while TX is idle
//   i_databyte     in   8  TX byte, captured on the accepting cycle
//   o_active       out  1  high while a TX frame is on the line
//   o_tx           out  1  serial TX line, idle high
//   o_done         out  1  one-cycle pulse when a TX frame completes
//   i_rx           in   1  serial RX line, asynchronous to clk, idle high
//   o_data_avail   out  1  one-cycle pulse: new byte on o_databyte
//   o_databyte     out  8  last good received byte, held until the next one
// -----------------------------------------------------------------------------
module uart_tx_rx #(
   parameter int clks_per_bit = 543
) (
   input  logic       clk,
   input  logic       rst_n,
   // transmitter
   input  logic       i_data_avail,
   input  logic [7:0] i_databyte,
   output logic       o_active,
   output logic       o_tx,
   output logic       o_done,
   // receiver
   input  logic       i_rx,
   output logic       o_data_avail,
   output logic [7:0] o_databyte
);

   localparam int              CNT_W    = $clog2(clks_per_bit);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clks_per_bit - 1);
   // Sampling point of the start bit; data and stop bits are then sampled one
   // full bit period apart, which lands them on their centres as well.
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((clks_per_bit - 1) / 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_DONE
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   // ---------------------------------------------------------------------------
   // Transmitter
   // ---------------------------------------------------------------------------
   tx_state_e        tx_state_q, tx_state_d;
   logic [CNT_W-1:0] tx_cnt_q,   tx_cnt_d;
   logic [2:0]       tx_bit_q,   tx_bit_d;
   logic [7:0]       tx_byte_q,  tx_byte_d;
   logic             tx_line_q,  tx_line_d;
   logic             tx_active_q, tx_active_d;
   logic             tx_done_q,  tx_done_d;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned; that is what keeps this block free of inferred latches.
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_bit_d    = tx_bit_q;
      tx_byte_d   = tx_byte_q;
      tx_line_d   = 1'b1;
      tx_active_d = 1'b0;
      tx_done_d   = 1'b0;

      unique case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (i_data_avail) begin
               tx_byte_d  = i_databyte;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = 3'd0;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_DONE;
            end else begin
               tx_cnt_d = tx_cnt_q + CNT_ONE;
            end
         end
         TX_DONE: begin
            tx_state_d = TX_IDLE;
         end
         default: begin
            tx_state_d = TX_IDLE;
         end
      endcase

      // Outputs are decoded from the next state and registered, so the pin
      // changes on the same edge as the state and never glitches between
      // data bits.
      unique case (tx_state_d)
         TX_START: begin
            tx_line_d   = 1'b0;
            tx_active_d = 1'b1;
         end
         TX_DATA: begin
            tx_line_d   = tx_byte_d[tx_bit_d];
            tx_active_d = 1'b1;
         end
         TX_STOP: begin
            tx_active_d = 1'b1;
         end
         TX_DONE: begin
            tx_done_d = 1'b1;
         end
         default: begin
            tx_line_d = 1'b1;
         end
      endcase
   end

   // NOTE: all state, including the data byte registers, is reset so an abort
   // leaves no stale frame behind and the line goes high at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= 3'd0;
         tx_byte_q   <= 8'h00;
         tx_line_q   <= 1'b1;
         tx_active_q <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments for every register so all flops see
         // the pre-edge values, independent of statement order.
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_byte_q   <= tx_byte_d;
         tx_line_q   <= tx_line_d;
         tx_active_q <= tx_active_d;
         tx_done_q   <= tx_done_d;
      end
   end

   assign o_tx     = tx_line_q;
   assign o_active = tx_active_q;
   assign o_done   = tx_done_q;

   // ---------------------------------------------------------------------------
   // Receiver
   // ---------------------------------------------------------------------------
   // Two-flop synchronizer for the asynchronous line; reset to the idle level
   // so leaving reset never looks like a start bit.
   logic rx_meta_q, rx_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_sync_q <= rx_meta_q;
      end
   end

   rx_state_e        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
   logic [2:0]       rx_bit_q,   rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic [7:0]       rx_byte_q,  rx_byte_d;
   logic             rx_avail_q, rx_avail_d;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_byte_d  = rx_byte_q;
      rx_avail_d = 1'b0;

      unique case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (!rx_sync_q) begin
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (rx_cnt_q == CNT_MID) begin
               rx_cnt_d = '0;
               rx_bit_d = 3'd0;
               // A line that is high again by mid start bit was a glitch.
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_ONE;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               // LSB arrives first: shift in from the top, after eight bits
               // the first one sits in bit 0.
               rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_ONE;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d = '0;
               // Back to idle at mid stop bit so a start bit that follows
               // immediately is still caught. A low stop bit is a framing
               // error and the byte is dropped.
               rx_state_d = RX_IDLE;
               if (rx_sync_q) begin
                  rx_byte_d  = rx_shift_q;
                  rx_avail_d = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CNT_ONE;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'h00;
         rx_byte_q  <= 8'h00;
         rx_avail_q <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_byte_q  <= rx_byte_d;
         rx_avail_q <= rx_avail_d;
      end
   end

   assign o_data_avail = rx_avail_q;
   assign o_databyte   = rx_byte_q;

endmodule

// File: tb/tb_uart_tx_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_rx
// Directed bench for uart_tx_rx. Instance dut_a (16 clocks per bit) covers the
// table of loopback frames, back-to-back frames, RX glitch / framing error and
// reset mid-frame; instance dut_b (543 clocks per bit) runs the full-rate
// loopback frame. Expected line patterns are written out by hand as
// {start, d0..d7, stop}, most significant bit first on the line.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_rx;

   localparam int N_A = 16;
   localparam int N_B = 543;

   logic       clk;
   logic       rst_n;

   // instance A: short bit period, RX either looped back or driven by bench
   logic       avail_a;
   logic [7:0] databyte_a;
   logic       active_a, tx_a, done_a, rx_avail_a;
   logic [7:0] rx_byte_a;
   logic       rx_a;
   logic       loop_a;
   logic       rx_drv;

   // instance B: full-rate loopback
   logic       avail_b;
   logic [7:0] databyte_b;
   logic       active_b, tx_b, done_b, rx_avail_b;
   logic [7:0] rx_byte_b;
   logic       rx_b;

   assign rx_a = loop_a ? tx_a : rx_drv;
   assign rx_b = tx_b;

   uart_tx_rx #(.clks_per_bit(N_A)) dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_data_avail (avail_a),
      .i_databyte   (databyte_a),
      .o_active     (active_a),
      .o_tx         (tx_a),
      .o_done       (done_a),
      .i_rx         (rx_a),
      .o_data_avail (rx_avail_a),
      .o_databyte   (rx_byte_a)
   );

   uart_tx_rx #(.clks_per_bit(N_B)) dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_data_avail (avail_b),
      .i_databyte   (databyte_b),
      .o_active     (active_b),
      .o_tx         (tx_b),
      .o_done       (done_b),
      .i_rx         (rx_b),
      .o_data_avail (rx_avail_b),
      .o_databyte   (rx_byte_b)
   );

   initial clk = 1'b0;
   always #2 clk = ~clk;

   // monitor view of whichever instance the frame task is driving
   bit         use_big;
   logic       m_tx, m_active, m_done, m_rx_avail;
   logic [7:0] m_rx_byte;
   assign m_tx       = use_big ? tx_b       : tx_a;
   assign m_active   = use_big ? active_b   : active_a;
   assign m_done     = use_big ? done_b     : done_a;
   assign m_rx_avail = use_big ? rx_avail_b : rx_avail_a;
   assign m_rx_byte  = use_big ? rx_byte_b  : rx_byte_a;

   int n_checks;
   int n_errors;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic v, input logic [7:0] d);
      if (use_big) begin
         avail_b    = v;
         databyte_b = d;
      end else begin
         avail_a    = v;
         databyte_a = d;
      end
   endtask

   // Send one byte and check the line bit by bit. Cycle i = 0 is the first
   // cycle after the accepting edge (first start-bit cycle); bit k occupies
   // cycles [k*n, (k+1)*n), and o_done is expected at cycle 10*n.
   task automatic run_frame(input logic [7:0] data, input logic [9:0] exp_line,
                            input logic [7:0] exp_rx, input bit toggle,
                            input int hold, input string name);
      int         n;
      int         bad_bits[10];
      int         active_bad;
      int         done_early;
      int         rx_cnt;
      int         post_bad;
      logic [7:0] rx_seen;
      logic       done_end, active_end, tx_end;
      n          = use_big ? N_B : N_A;
      active_bad = 0;
      done_early = 0;
      rx_cnt     = 0;
      post_bad   = 0;
      rx_seen    = 8'h00;
      done_end   = 1'b0;
      active_end = 1'b1;
      tx_end     = 1'b0;
      for (int k = 0; k < 10; k++) bad_bits[k] = 0;

      set_req(1'b1, data);
      for (int i = 0; i <= 10 * n; i++) begin
         tick();
         if (i < 10 * n) begin
            if (m_tx !== exp_line[9 - i / n]) bad_bits[i / n]++;
            if (m_active !== 1'b1) active_bad++;
            if (m_done !== 1'b0) done_early++;
         end else begin
            done_end   = m_done;
            active_end = m_active;
            tx_end     = m_tx;
         end
         if (m_rx_avail === 1'b1) begin
            rx_cnt++;
            rx_seen = m_rx_byte;
         end
         if (toggle && i < 10 * n - 4) set_req(((i % 5) == 2), ~data ^ 8'(i));
         else if (i + 1 >= hold) set_req(1'b0, data);
      end

      for (int k = 0; k < 10; k++)
         check($sformatf("%s bit%0d wrong cycles", name, k), bad_bits[k], 0);
      check({name, " active dropped"}, active_bad, 0);
      check({name, " early done"}, done_early, 0);
      check({name, " done at 10 bits"}, done_end, 1);
      check({name, " active low at done"}, active_end, 0);
      check({name, " tx high at done"}, tx_end, 1);
      check({name, " rx pulses"}, rx_cnt, 1);
      check({name, " rx byte"}, rx_seen, exp_rx);

      // line must stay idle: no second frame, no stray pulses
      for (int i = 0; i < 2 * n; i++) begin
         tick();
         if (m_active !== 1'b0 || m_done !== 1'b0 || m_rx_avail !== 1'b0 || m_tx !== 1'b1)
            post_bad++;
      end
      check({name, " idle after frame"}, post_bad, 0);
   endtask

   // Drive one frame directly onto dut_a's RX line and count pulses. A bad
   // stop bit is held low only for 3/4 of the bit (covering its centre), so
   // the line is high again before any re-armed start check.
   task automatic drive_rx(input logic [7:0] b, input bit stop_ok,
                           output int pulses, output logic [7:0] seen);
      pulses = 0;
      seen   = 8'h00;
      for (int i = 0; i < 13 * N_A; i++) begin
         logic v;
         if (i < N_A) v = 1'b0;
         else if (i < 9 * N_A) v = b[i / N_A - 1];
         else if (i < 10 * N_A) v = stop_ok || (i - 9 * N_A >= (3 * N_A) / 4);
         else v = 1'b1;
         rx_drv = v;
         tick();
         if (rx_avail_a === 1'b1) begin
            pulses++;
            seen = rx_byte_a;
         end
      end
   endtask

   typedef struct {
      logic [7:0] data;
      logic [9:0] exp_line;
      logic [7:0] exp_rx;
      bit         toggle;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int         pulses;
      logic [7:0] seen;
      int         starts[$];
      int         dones[$];
      logic [7:0] rxb[$];
      logic       prev_act;
      int         bad;

      vecs[0] = '{8'hAB, 10'b0110101011, 8'hAB, 1'b0};
      vecs[1] = '{8'h00, 10'b0000000001, 8'h00, 1'b0};
      vecs[2] = '{8'hFF, 10'b0111111111, 8'hFF, 1'b0};
      vecs[3] = '{8'h5A, 10'b0010110101, 8'h5A, 1'b1};
      vecs[4] = '{8'h01, 10'b0100000001, 8'h01, 1'b0};
      vecs[5] = '{8'h80, 10'b0000000011, 8'h80, 1'b0};
      vecs[6] = '{8'hC3, 10'b0110000111, 8'hC3, 1'b1};

      n_checks   = 0;
      n_errors   = 0;
      use_big    = 1'b0;
      loop_a     = 1'b1;
      rx_drv     = 1'b1;
      avail_a    = 1'b0;
      databyte_a = 8'h00;
      avail_b    = 1'b0;
      databyte_b = 8'h00;
      rst_n      = 1'b0;

      // ---- reset state ----
      repeat (4) tick();
      check("reset tx_a", tx_a, 1);
      check("reset active_a", active_a, 0);
      check("reset done_a", done_a, 0);
      check("reset rx_avail_a", rx_avail_a, 0);
      check("reset rx_byte_a", rx_byte_a, 8'h00);
      check("reset dut_b outputs", {tx_b, active_b, done_b, rx_avail_b, rx_byte_b},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      rst_n = 1'b1;
      repeat (3) tick();

      // ---- table-driven loopback frames ----
      for (int v = 0; v < 7; v++)
         run_frame(vecs[v].data, vecs[v].exp_line, vecs[v].exp_rx, vecs[v].toggle, 1,
                   $sformatf("vec%0d", v));

      // ---- back-to-back 00 then FF, request held high ----
      starts.delete();
      dones.delete();
      rxb.delete();
      prev_act = active_a;
      set_req(1'b1, 8'h00);
      for (int i = 0; i < 25 * N_A; i++) begin
         tick();
         if (active_a && !prev_act) begin
            starts.push_back(i);
            if (starts.size() == 1) set_req(1'b1, 8'hFF);
            else set_req(1'b0, 8'hFF);
         end
         prev_act = active_a;
         if (done_a) dones.push_back(i);
         if (rx_avail_a) rxb.push_back(rx_byte_a);
      end
      check("b2b frame count", starts.size(), 2);
      check("b2b done count", dones.size(), 2);
      check("b2b rx count", rxb.size(), 2);
      check("b2b frame1 length",
            ((dones.size() > 0 && starts.size() > 0) ? dones[0] - starts[0] : -1), 10 * N_A);
      // DONE cycle, one IDLE cycle accepting the held request, then START
      check("b2b restart gap",
            ((starts.size() > 1 && dones.size() > 0) ? starts[1] - dones[0] : -1), 2);
      check("b2b frame2 length",
            ((dones.size() > 1 && starts.size() > 1) ? dones[1] - starts[1] : -1), 10 * N_A);
      check("b2b rx byte0", ((rxb.size() > 0) ? rxb[0] : 8'h55), 8'h00);
      check("b2b rx byte1", ((rxb.size() > 1) ? rxb[1] : 8'h55), 8'hFF);

      // ---- RX glitch, good frame, framing error, good frame ----
      rx_drv = 1'b1;
      loop_a = 1'b0;
      repeat (4) tick();
      rx_drv = 1'b0;
      repeat (5) tick();
      rx_drv = 1'b1;
      pulses = 0;
      for (int i = 0; i < 3 * N_A; i++) begin
         tick();
         if (rx_avail_a) pulses++;
      end
      check("glitch no pulse", pulses, 0);
      check("glitch byte held", rx_byte_a, 8'hFF);

      drive_rx(8'h3C, 1'b1, pulses, seen);
      check("rx 3C pulses", pulses, 1);
      check("rx 3C byte", seen, 8'h3C);

      drive_rx(8'h5A, 1'b0, pulses, seen);
      check("framing err no pulse", pulses, 0);
      check("framing err byte held", rx_byte_a, 8'h3C);

      drive_rx(8'hE7, 1'b1, pulses, seen);
      check("rx E7 pulses", pulses, 1);
      check("rx E7 byte", seen, 8'hE7);
      loop_a = 1'b1;
      repeat (4) tick();

      // ---- reset during TX data bit 3 ----
      set_req(1'b1, 8'h96);
      for (int i = 0; i <= 4 * N_A + 5; i++) begin
         tick();
         if (i == 0) set_req(1'b0, 8'h96);
      end
      check("pre-reset in data bit3", {active_a, tx_a}, {1'b1, 1'b0});
      rst_n = 1'b0;
      #1;
      check("mid-frame reset tx", tx_a, 1);
      check("mid-frame reset active", active_a, 0);
      check("mid-frame reset done", done_a, 0);
      repeat (3) tick();
      rst_n = 1'b1;
      check("post-reset rx byte", rx_byte_a, 8'h00);
      bad = 0;
      for (int i = 0; i < 12 * N_A; i++) begin
         tick();
         if (done_a || rx_avail_a || active_a || !tx_a) bad++;
      end
      check("aborted frame stays quiet", bad, 0);
      run_frame(8'h96, 10'b0011010011, 8'h96, 1'b0, 1, "after reset");

      // ---- full-rate loopback, request held 12 cycles ----
      use_big = 1'b1;
      run_frame(8'hAB, 10'b0110101011, 8'hAB, 1'b0, 12, "lb543");
      use_big = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
